// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_pkg
//  Description : Shared widths, EX function codes and FSM state type for the
//                multiply/divide unit controller and its divider core.
//                Also provides the "absolute value when signed" helper used
//                when launching a divide.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    localparam int W_DATA = 32;
    localparam int W_FUNC = 6;

    // MIPS SPECIAL funct codes; the signed/unsigned variant arrives on 'sign'.
    localparam logic [W_FUNC-1:0] FUNC_MULT = 6'h18;
    localparam logic [W_FUNC-1:0] FUNC_DIV  = 6'h1A;
    localparam logic [W_FUNC-1:0] FUNC_MTHI = 6'h11;
    localparam logic [W_FUNC-1:0] FUNC_MTLO = 6'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Magnitude of a value that is two's complement only when is_signed=1.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [W_DATA-1:0] abs_if_signed(input logic              is_signed,
                                                        input logic [W_DATA-1:0] value);
        return (is_signed && value[W_DATA-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage : mdu_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Unsigned 32-bit restoring divider, one quotient bit per
//                enabled cycle. 'start' loads the operands; 32 enabled cycles
//                later quotient/remainder are final and held until the next
//                start. A zero divisor yields quotient all-ones and
//                remainder equal to the dividend.
//  Ports       : clk, rst        - clock, async active-high reset
//                start           - load dividend/divisor, clear remainder
//                en              - perform one iteration this cycle
//                dividend/divisor- unsigned operands
//                quotient/remainder - results
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import mdu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [W_DATA-1:0] dividend,
    input  logic [W_DATA-1:0] divisor,
    output logic [W_DATA-1:0] quotient,
    output logic [W_DATA-1:0] remainder
);

    // The quotient register doubles as the dividend shift register: each
    // iteration shifts its MSB into the partial remainder and its LSB gets
    // the new quotient bit.
    logic [W_DATA-1:0] r_quo;
    logic [W_DATA-1:0] r_rem;
    logic [W_DATA-1:0] r_div;

    logic [W_DATA:0]   w_shift;
    logic [W_DATA:0]   w_diff;

    assign w_shift = {r_rem, r_quo[W_DATA-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (start) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_div <= divisor;
        end else if (en) begin
            // Partial remainder never exceeds 32 bits: it stays below a
            // non-zero divisor, or is a dividend prefix when divisor is 0.
            if (!w_diff[W_DATA]) begin
                r_rem <= w_diff[W_DATA-1:0];
                r_quo <= {r_quo[W_DATA-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[W_DATA-1:0];
                r_quo <= {r_quo[W_DATA-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule : div_iter
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : EX-stage multiply/divide sequencing controller. Launches
//                MULT/DIV from IDLE with latched operands, stalls the
//                pipeline while busy, and pulses a single HI/LO write-back
//                per completed operation. MTHI/MTLO write in the same cycle
//                without stalling. 'flush' cancels any in-flight operation.
//  Ports       : clk, rst              - clock, async active-high reset
//                req, sign, func       - EX instruction valid / signedness / op
//                source_a, source_b    - rs / rt operands
//                flush                 - synchronous cancel
//                alu_stall, busy       - pipeline freeze / controller active
//                hi_write(_data)       - HI write-back
//                lo_write(_data)       - LO write-back
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DATA_W     = W_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              sign,
    input  logic [W_FUNC-1:0] func,
    input  logic [DATA_W-1:0] source_a,
    input  logic [DATA_W-1:0] source_b,
    input  logic              flush,
    output logic              alu_stall,
    output logic              busy,
    output logic              hi_write,
    output logic [DATA_W-1:0] hi_write_data,
    output logic              lo_write,
    output logic [DATA_W-1:0] lo_write_data
);

    localparam int          CNT_W      = 5;
    localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DATA_W - 1);

    mdu_state_t          r_state;
    mdu_state_t          w_next;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic                r_sign;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_is_mult;
    logic                w_is_div;
    logic                w_launch;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_div_q;
    logic [DATA_W-1:0]   w_div_r;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    assign w_is_mult = (func == FUNC_MULT);
    assign w_is_div  = (func == FUNC_DIV);
    assign w_launch  = (r_state == IDLE) && req && !flush && (w_is_mult || w_is_div);

    // Divider loads magnitudes on the launch edge and iterates only in DIV,
    // so its outputs stay frozen through DONE.
    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (w_launch && w_is_div),
        .en        (r_state == DIV),
        .dividend  (abs_if_signed(sign, source_a)),
        .divisor   (abs_if_signed(sign, source_b)),
        .quotient  (w_div_q),
        .remainder (w_div_r)
    );

    // Sign-extending to 64 bits and keeping the low 64 bits of the product
    // gives the correct two's-complement result for signed operands and the
    // plain product for unsigned ones.
    assign w_a_ext   = {{DATA_W{r_sign & r_op_a[DATA_W-1]}}, r_op_a};
    assign w_b_ext   = {{DATA_W{r_sign & r_op_b[DATA_W-1]}}, r_op_b};
    assign w_product = w_a_ext * w_b_ext;

    assign w_quot = r_neg_q ? (~w_div_q + 1'b1) : w_div_q;
    assign w_rem  = r_neg_r ? (~w_div_r + 1'b1) : w_div_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_sign   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_op_a   <= source_a;
                r_op_b   <= source_b;
                r_sign   <= sign;
                r_is_div <= w_is_div;
                r_neg_q  <= sign & (source_a[DATA_W-1] ^ source_b[DATA_W-1]);
                r_neg_r  <= sign & source_a[DATA_W-1];
                r_count  <= '0;
            end else if (r_state == MUL || r_state == DIV) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        alu_stall     = 1'b0;
        hi_write      = 1'b0;
        hi_write_data = '0;
        lo_write      = 1'b0;
        lo_write_data = '0;

        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_next    = w_is_div ? DIV : MUL;
                    alu_stall = 1'b1;
                end else if (req && !flush && func == FUNC_MTHI) begin
                    hi_write      = 1'b1;
                    hi_write_data = source_a;
                end else if (req && !flush && func == FUNC_MTLO) begin
                    lo_write      = 1'b1;
                    lo_write_data = source_a;
                end
            end
            MUL: begin
                alu_stall = 1'b1;
                if (flush)                        w_next = IDLE;
                else if (r_count == C_MUL_LAST)   w_next = DONE;
            end
            DIV: begin
                alu_stall = 1'b1;
                if (flush)                        w_next = IDLE;
                else if (r_count == C_DIV_LAST)   w_next = DONE;
            end
            DONE: begin
                // req is still the completed instruction here; never relaunch.
                w_next = IDLE;
                if (!flush) begin
                    hi_write      = 1'b1;
                    lo_write      = 1'b1;
                    hi_write_data = r_is_div ? w_rem  : w_product[2*DATA_W-1:DATA_W];
                    lo_write_data = r_is_div ? w_quot : w_product[DATA_W-1:0];
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

endmodule : mdu_ctrl
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the EX-stage multiply/divide unit of the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, latches the operands, and runs either a fixed-latency multiply or a 32-iteration divide. It raises the pipeline stall while busy and issues exactly one HI/LO write-back per completed operation. It also cancels in-flight work on an exception flush.

Parameters:
MUL_CYCLES, 2, cycles spent in MUL state (range 1..15)
DATA_W, 32, operand/HI/LO width (fixed to W_DATA)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req  in  1  EX holds a valid MDU instruction this cycle
sign  in  1  1 = signed op (MULT/DIV), 0 = unsigned
func  in  W_FUNC  FUNC_MULT/FUNC_DIV/FUNC_MTHI/FUNC_MTLO; any other value is ignored
source_a  in  32  rs operand
source_b  in  32  rt operand
flush  in  1  synchronous cancel from the exception unit
alu_stall  out  1  freeze the pipeline
busy  out  1  state != IDLE
hi_write  out  1  HI write enable
hi_write_data  out  32  HI write value
lo_write  out  1  LO write enable
lo_write_data  out  32  LO write value

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, operand regs=0; all outputs 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, req & FUNC_MULT & !flush: latch operands and sign, counter=0, go MUL. alu_stall=1 this cycle (combinational).
- IDLE, req & FUNC_DIV & !flush: latch |a|, |b|, neg_q=sign&(a[31]^b[31]), neg_r=sign&a[31]; go DIV; alu_stall=1.
- IDLE, req & MTHI/MTLO & !flush: hi_write (or lo_write)=1 and data=source_a in the same cycle. No stall; state stays IDLE.
- MUL: counter increments each cycle; at counter==MUL_CYCLES-1 go DONE. Product is 64-bit, signed or unsigned per the latched sign.
- DIV: one restoring iteration per cycle for 32 cycles (counter 0..31), then go DONE.
- DONE: alu_stall=0. Write HI=product[63:32] or remainder, LO=product[31:0] or quotient; both writes pulse for exactly one cycle. Next state is IDLE unconditionally; req seen in DONE is the same instruction and never relaunches.
- alu_stall = (IDLE & req & MULT/DIV & !flush) | state==MUL | state==DIV.
- Latency from launch cycle t0:
  - MUL: write at t0+MUL_CYCLES+1 (t3 at default).
  - DIV: write at t0+33.
- Signed divide fixup: q = neg_q ? -q : q; r = neg_r ? -r : r. For 0x80000000 / -1 (signed), q=0x80000000, r=0.
- Divide by zero: the unsigned core yields q=0xFFFFFFFF, r=|a|, then the sign fixup is applied. No exception.
- flush in MUL/DIV/DONE: next state IDLE, no HI/LO write. In DONE, flush suppresses that cycle's writes combinationally.
- flush in IDLE: nothing launches and MTHI/MTLO writes are suppressed.
- Operands are latched at launch, so source_a/source_b may change while stalled.
- Reset asserted mid-operation aborts immediately with no write.

Decomposition:
- Shared package (includes): W_DATA, W_FUNC, FUNC_MULT, FUNC_DIV, FUNC_MTHI, FUNC_MTLO.
- Package typedef: mdu_state_t enum {IDLE, MUL, DIV, DONE}.
- Sub-module div_iter: unsigned 32-bit restoring divider.
  - Inputs: clk, rst, start, dividend, divisor.
  - Outputs: quotient, remainder.
  - One iteration per cycle while enabled.
- The controller owns counter, sign fixup, multiply and write-back.

Test Plan:
- Signed DIV 19 / -4 -> alu_stall high 33 cycles; then lo_write=1 with 0xFFFFFFFC and hi_write=1 with 0x00000003 for exactly one cycle.
- Unsigned MULT 0xFFFFFFFF * 2 -> HI=0x00000001, LO=0xFFFFFFFE written at t0+3. Signed MULT of the same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007. Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 with req in IDLE -> hi_write=1 and data=0x12345678 the same cycle, alu_stall=0, lo_write=0.
- DIV launched, flush at t10 -> state IDLE at t11; no hi_write/lo_write ever. A following MULT 3*5 gives LO=15, HI=0.
- rst asserted at t5 of a DIV, asynchronously between edges -> outputs 0 immediately; after release, busy=0 and no write occurs.
